// File: rtl/fisc_flag_unit_pkg.sv
// Shared types for the FISC flag unit: condition codes, NZCV bit positions, result FSM states.
// Imported by the flag unit top and the condition evaluator.
package fisc_flag_unit_pkg;

  localparam int FISC_FLAGS_SZ = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } fisc_cond_e;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/fisc_flag_unit_cond_eval.sv
// Combinational ARM-style condition evaluator: (cond_code, NZCV) -> taken.
// Zero latency; no flow control. Reusable by the branch unit.
module fisc_flag_unit_cond_eval
  import fisc_flag_unit_pkg::*;
(
  input  logic [3:0]               cond_code_i,
  input  logic [FISC_FLAGS_SZ-1:0] nzcv_i,
  output logic                     taken_o
);

  logic n, z, c, v;
  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    taken_o = 1'b1;
    case (fisc_cond_e'(cond_code_i))
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_HS: taken_o = c;
      COND_LO: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !c || z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = z || (n != v);
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fisc_flag_unit.sv
// Architectural NZCV register plus in-flight writer tracking and a 1-deep registered B.cond result.
// Optional same-cycle write-back bypass for queries is enabled by defining FISC_FLAG_FWD_EN.
module fisc_flag_unit
  import fisc_flag_unit_pkg::*;
#(
  parameter int PEND_DEPTH = 3,
  parameter int CNT_W      = $clog2(PEND_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     issue_set_flg_i,
  output logic                     issue_ready_o,
  input  logic                     wr_valid_i,
  input  logic [FISC_FLAGS_SZ-1:0] wr_nzcv_i,
  input  logic                     cond_valid_i,
  input  logic [3:0]               cond_code_i,
  output logic                     cond_ready_o,
  output logic                     res_valid_o,
  output logic                     res_taken_o,
  input  logic                     res_ready_i,
  output logic [FISC_FLAGS_SZ-1:0] flags_o,
  output logic [CNT_W-1:0]         pend_cnt_o,
  output logic                     err_underflow_o
);

  logic [CNT_W-1:0]         pend_cnt_q, pend_cnt_d;
  logic [FISC_FLAGS_SZ-1:0] flags_q, flags_d;
  logic [FISC_FLAGS_SZ-1:0] eval_nzcv;
  logic                     err_q, err_d;
  logic                     res_taken_q;
  res_state_e               state_q;
  logic                     inc, dec, flags_clean, accept, taken;

  assign issue_ready_o = pend_cnt_q < CNT_W'(PEND_DEPTH);
  assign inc = issue_set_flg_i && issue_ready_o;
  assign dec = wr_valid_i && (pend_cnt_q != '0);

  // A same-cycle issue is younger than the query, so only the registered count gates it.
`ifdef FISC_FLAG_FWD_EN
  logic fwd_hit;
  assign fwd_hit     = wr_valid_i && (pend_cnt_q == CNT_W'(1));
  assign flags_clean = (pend_cnt_q == '0) || fwd_hit;
  assign eval_nzcv   = fwd_hit ? wr_nzcv_i : flags_q;
`else
  assign flags_clean = (pend_cnt_q == '0);
  assign eval_nzcv   = flags_q;
`endif

  assign cond_ready_o = flags_clean && ((state_q == RES_EMPTY) || res_ready_i);
  assign accept       = cond_valid_i && cond_ready_o;

  fisc_flag_unit_cond_eval u_cond_eval (
    .cond_code_i (cond_code_i),
    .nzcv_i      (eval_nzcv),
    .taken_o     (taken)
  );

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (inc && !dec) begin
      pend_cnt_d = pend_cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      pend_cnt_d = pend_cnt_q - CNT_W'(1);
    end
    flags_d = dec ? wr_nzcv_i : flags_q;
    err_d   = err_q || (wr_valid_i && (pend_cnt_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_cnt_q <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= RES_EMPTY;
      res_taken_q <= 1'b0;
    end else begin
      case (state_q)
        RES_EMPTY: begin
          if (accept) begin
            state_q     <= RES_FULL;
            res_taken_q <= taken;
          end
        end
        RES_FULL: begin
          if (accept) begin
            res_taken_q <= taken;
          end else if (res_ready_i) begin
            state_q <= RES_EMPTY;
          end
        end
        default: state_q <= RES_EMPTY;
      endcase
    end
  end

  assign res_valid_o     = (state_q == RES_FULL);
  assign res_taken_o     = res_taken_q;
  assign flags_o         = flags_q;
  assign pend_cnt_o      = pend_cnt_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_fisc_flag_unit.sv
// Self-checking bench for fisc_flag_unit: directed scenarios then random traffic against a reference model.
// Honours FISC_FLAG_FWD_EN the same way the design does.
module tb_fisc_flag_unit;

  logic       clk_i = 1'b0;
  logic       rst_n_i, issue_set_flg_i, wr_valid_i, cond_valid_i, res_ready_i;
  logic [3:0] wr_nzcv_i, cond_code_i;
  logic       issue_ready_o, cond_ready_o, res_valid_o, res_taken_o, err_underflow_o;
  logic [3:0] flags_o;
  logic [1:0] pend_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int       m_pend;
  bit [3:0] m_flags;
  bit       m_err, m_valid, m_taken;

  fisc_flag_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .issue_set_flg_i(issue_set_flg_i), .issue_ready_o(issue_ready_o),
    .wr_valid_i(wr_valid_i), .wr_nzcv_i(wr_nzcv_i),
    .cond_valid_i(cond_valid_i), .cond_code_i(cond_code_i), .cond_ready_o(cond_ready_o),
    .res_valid_o(res_valid_o), .res_taken_o(res_taken_o), .res_ready_i(res_ready_i),
    .flags_o(flags_o), .pend_cnt_o(pend_cnt_o), .err_underflow_o(err_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Even codes test a base predicate, odd codes its inverse; NV is the exception (always true).
  function automatic bit cond_ref(int code, bit [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c & ~z;
      5: base = (n == v);
      6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (code == 15) return 1'b1;
    return (code % 2 == 1) ? ~base : base;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check handshake outputs, clock, update model, check state outputs.
  task automatic step(bit rn, bit iss, bit wr, bit [3:0] nzcv, bit cv, bit [3:0] cc, bit rr);
    bit fwd, clean, cr, acc;
    bit [3:0] src;
    int inc, dec;
    rst_n_i = rn; issue_set_flg_i = iss; wr_valid_i = wr; wr_nzcv_i = nzcv;
    cond_valid_i = cv; cond_code_i = cc; res_ready_i = rr;
    #3;
`ifdef FISC_FLAG_FWD_EN
    fwd = wr && (m_pend == 1);
`else
    fwd = 1'b0;
`endif
    clean = (m_pend == 0) || fwd;
    cr    = clean && (!m_valid || rr);
    if (rn) begin
      check("issue_ready", {7'd0, issue_ready_o}, {7'd0, m_pend < 3});
      check("cond_ready", {7'd0, cond_ready_o}, {7'd0, cr});
    end
    @(posedge clk_i);
    if (!rn) begin
      m_pend = 0; m_flags = 0; m_err = 0; m_valid = 0; m_taken = 0;
    end else begin
      acc = cv && cr;
      src = fwd ? nzcv : m_flags;
      if (acc) begin
        m_valid = 1'b1;
        m_taken = cond_ref(int'(cc), src);
      end else if (m_valid && rr) begin
        m_valid = 1'b0;
      end
      inc = (iss && m_pend < 3) ? 1 : 0;
      dec = (wr && m_pend > 0) ? 1 : 0;
      if (wr && m_pend > 0) m_flags = nzcv;
      if (wr && m_pend == 0) m_err = 1'b1;
      m_pend = m_pend + inc - dec;
    end
    #1;
    check("res_valid", {7'd0, res_valid_o}, {7'd0, m_valid});
    check("res_taken", {7'd0, res_taken_o}, {7'd0, m_taken});
    check("flags", {4'd0, flags_o}, {4'd0, m_flags});
    check("pend_cnt", {6'd0, pend_cnt_o}, 8'(m_pend));
    check("err_underflow", {7'd0, err_underflow_o}, {7'd0, m_err});
  endtask

  initial begin
    m_pend = 0; m_flags = 0; m_err = 0; m_valid = 0; m_taken = 0;
    rst_n_i = 0; issue_set_flg_i = 0; wr_valid_i = 0; wr_nzcv_i = 0;
    cond_valid_i = 0; cond_code_i = 0; res_ready_i = 0;
    @(posedge clk_i); #1;
    step(0, 0, 0, 4'h0, 0, 4'h0, 0);

    // Reset while a result is held and two writers are pending
    step(1, 1, 0, 4'h0, 1, 4'hE, 0);
    step(1, 1, 0, 4'h0, 0, 4'h0, 0);
    check("pre_rst_pend", {6'd0, pend_cnt_o}, 8'd2);
    check("pre_rst_valid", {7'd0, res_valid_o}, 8'd1);
    step(0, 1, 1, 4'hF, 1, 4'hE, 0);
    check("rst_valid", {7'd0, res_valid_o}, 8'd0);
    check("rst_taken", {7'd0, res_taken_o}, 8'd0);
    check("rst_pend", {6'd0, pend_cnt_o}, 8'd0);
    check("rst_flags", {4'd0, flags_o}, 8'd0);
    check("rst_err", {7'd0, err_underflow_o}, 8'd0);

    // Flag write and EQ query in the same cycle
    step(1, 1, 0, 4'h0, 0, 4'h0, 1);
    step(1, 0, 1, 4'b0100, 1, 4'h0, 1);
`ifdef FISC_FLAG_FWD_EN
    check("fwd_valid", {7'd0, res_valid_o}, 8'd1);
    check("fwd_taken", {7'd0, res_taken_o}, 8'd1);
    step(1, 0, 0, 4'h0, 0, 4'h0, 1);
`else
    check("nofwd_stall", {7'd0, res_valid_o}, 8'd0);
    step(1, 0, 0, 4'h0, 1, 4'h0, 1);
    check("nofwd_valid", {7'd0, res_valid_o}, 8'd1);
    check("nofwd_taken", {7'd0, res_taken_o}, 8'd1);
    step(1, 0, 0, 4'h0, 0, 4'h0, 1);
`endif

    // Four back-to-back issues saturate at PEND_DEPTH
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4'h0, 0, 4'h0, 1);
    check("sat_pend", {6'd0, pend_cnt_o}, 8'd3);
    check("sat_issue_ready", {7'd0, issue_ready_o}, 8'd0);
    step(1, 0, 1, 4'b1000, 0, 4'h0, 1);
    step(1, 0, 1, 4'b0001, 0, 4'h0, 1);
    step(1, 0, 1, 4'b0010, 0, 4'h0, 1);

    // Underflow write is ignored but sticky-flagged
    step(1, 0, 1, 4'b1111, 0, 4'h0, 1);
    check("uf_flags", {4'd0, flags_o}, 8'h02);
    check("uf_err", {7'd0, err_underflow_o}, 8'd1);
    step(1, 0, 0, 4'h0, 0, 4'h0, 1);
    check("uf_sticky", {7'd0, err_underflow_o}, 8'd1);

    // Full condition table
    for (int code = 0; code < 16; code++) begin
      for (int f = 0; f < 16; f++) begin
        step(1, 1, 0, 4'h0, 0, 4'h0, 1);
        step(1, 0, 1, 4'(f), 0, 4'h0, 1);
        step(1, 0, 0, 4'h0, 1, 4'(code), 1);
        check("cond_table", {7'd0, res_taken_o}, {7'd0, cond_ref(code, 4'(f))});
      end
    end
    step(1, 0, 0, 4'h0, 0, 4'h0, 1);

    // Held result under backpressure, then back-to-back handoff
    step(1, 1, 0, 4'h0, 0, 4'h0, 1);
    step(1, 0, 1, 4'b0100, 0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 1, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 4'h0, 1, 4'h1, 0);
      check("hold_valid", {7'd0, res_valid_o}, 8'd1);
      check("hold_taken", {7'd0, res_taken_o}, 8'd1);
    end
    step(1, 0, 0, 4'h0, 1, 4'h1, 1);
    check("b2b_valid", {7'd0, res_valid_o}, 8'd1);
    check("b2b_taken", {7'd0, res_taken_o}, 8'd0);
    step(1, 0, 0, 4'h0, 0, 4'h0, 1);
    check("drain_valid", {7'd0, res_valid_o}, 8'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
           1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
